// File: rtl/shot_sequencer.sv
// shot_sequencer: initiator side of the Battleship shot/score handshake.
// Synchronises and debounces KEY[0], latches and validates the target square and
// big-bomb request, issues a one-cycle score request and keeps game bookkeeping.
//
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_key_n                 fire key, active-low, asynchronous
//   i_x_in, i_y_in          target column / row (valid 1..10)
//   i_big_req               big-bomb request
//   o_shot_x/y/big          latched shot presented to the responder
//   o_score_this            one-cycle request pulse
//   i_res_valid, i_res_*    responder result strobe and flags
//   o_busy, o_wrong         request outstanding / last press rejected or timed out
//   o_led_*                 last result flags, held
//   o_ship_mask             sticky OR of reported ships
//   o_big_left, o_shots_left remaining big bombs and shots
//   o_hit_ones, o_hit_tens  BCD hit count (saturates at 99)
//   o_game_over             sticky end of game
module shot_sequencer #(
  parameter int unsigned SYNC_STAGES     = 2,  // must be >= 2
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MAX_SHOTS       = 20,
  parameter int unsigned BIG_BOMBS       = 2,  // 0..2
  parameter int unsigned SHIP_SQUARES    = 19,
  parameter int unsigned TIMEOUT         = 15
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_key_n,
  input  logic [3:0] i_x_in,
  input  logic [3:0] i_y_in,
  input  logic       i_big_req,
  output logic [3:0] o_shot_x,
  output logic [3:0] o_shot_y,
  output logic       o_shot_big,
  output logic       o_score_this,
  input  logic       i_res_valid,
  input  logic       i_res_hit,
  input  logic       i_res_near,
  input  logic       i_res_miss,
  input  logic [4:0] i_res_ship,
  output logic       o_busy,
  output logic       o_wrong,
  output logic       o_led_hit,
  output logic       o_led_near,
  output logic       o_led_miss,
  output logic [4:0] o_ship_mask,
  output logic [1:0] o_big_left,
  output logic [4:0] o_shots_left,
  output logic [3:0] o_hit_ones,
  output logic [3:0] o_hit_tens,
  output logic       o_game_over
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT - 1);
  localparam logic [6:0]      SHIP_TARGET = 7'(SHIP_SQUARES);

  typedef enum logic [2:0] {StIdle, StCheck, StIssue, StWait, StOver} state_e;

  state_e r_state, w_next_state;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_key_lvl;
  logic [DB_W-1:0]        r_db_cnt;
  logic [TO_W-1:0]        r_to_cnt;
  logic [99:0]            r_history;
  logic [3:0]             r_shot_x, r_shot_y;
  logic                   r_shot_big;
  logic                   r_wrong;
  logic                   r_led_hit, r_led_near, r_led_miss;
  logic [4:0]             r_ship_mask;
  logic [1:0]             r_big_left;
  logic [4:0]             r_shots_left;
  logic [3:0]             r_hit_ones, r_hit_tens;

  logic       w_key_sync, w_db_done, w_press;
  logic       w_x_ok, w_y_ok, w_fired, w_bad;
  logic [6:0] w_sq_idx, w_hits_bin;
  logic [3:0] w_ones_nxt, w_tens_nxt;
  logic [4:0] w_shots_nxt;
  logic       w_latch, w_accept, w_reject, w_commit, w_timeout;

  // Key synchroniser; idles high so reset never looks like a press.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_sync <= '1;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_key_n};
  end

  assign w_key_sync = r_sync[SYNC_STAGES-1];
  // Level change accepted once the new level has been seen DEBOUNCE_CYCLES cycles running.
  assign w_db_done  = (w_key_sync != r_key_lvl) && (r_db_cnt == DB_LAST);
  assign w_press    = w_db_done && !w_key_sync;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_key_lvl <= 1'b1;
      r_db_cnt  <= '0;
    end else if (w_key_sync == r_key_lvl) begin
      r_db_cnt  <= '0;
    end else if (w_db_done) begin
      r_key_lvl <= w_key_sync;
      r_db_cnt  <= '0;
    end else begin
      r_db_cnt  <= r_db_cnt + DB_W'(1);
    end
  end

  // Square validation; the history index is only meaningful when both coords are in range.
  assign w_x_ok   = (r_shot_x >= 4'd1) && (r_shot_x <= 4'd10);
  assign w_y_ok   = (r_shot_y >= 4'd1) && (r_shot_y <= 4'd10);
  assign w_sq_idx = {3'b000, r_shot_y} * 7'd10 + {3'b000, r_shot_x} - 7'd11;
  assign w_fired  = w_x_ok && w_y_ok && r_history[w_sq_idx];
  assign w_bad    = !w_x_ok || !w_y_ok || (r_shot_big && (r_big_left == 2'd0)) || w_fired;

  // BCD hit counter next value, saturating at 99.
  always_comb begin
    w_ones_nxt = r_hit_ones;
    w_tens_nxt = r_hit_tens;
    if (i_res_hit) begin
      if (r_hit_ones == 4'd9) begin
        if (r_hit_tens != 4'd9) begin
          w_ones_nxt = 4'd0;
          w_tens_nxt = r_hit_tens + 4'd1;
        end
      end else begin
        w_ones_nxt = r_hit_ones + 4'd1;
      end
    end
  end

  assign w_hits_bin  = {3'b000, w_tens_nxt} * 7'd10 + {3'b000, w_ones_nxt};
  assign w_shots_nxt = r_shots_left - 5'd1;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_commit     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_press) begin
          w_latch      = 1'b1;
          w_next_state = StCheck;
        end
      end
      StCheck: begin
        if (w_bad) begin
          w_reject     = 1'b1;
          w_next_state = StIdle;
        end else begin
          w_accept     = 1'b1;
          w_next_state = StIssue;
        end
      end
      StIssue: w_next_state = StWait;
      StWait: begin
        // A result in the final allowed cycle beats the timeout.
        if (i_res_valid) begin
          w_commit = 1'b1;
          if ((w_hits_bin == SHIP_TARGET) || (w_shots_nxt == 5'd0)) w_next_state = StOver;
          else                                                      w_next_state = StIdle;
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout    = 1'b1;
          w_next_state = StIdle;
        end
      end
      StOver:  w_next_state = StOver;
      default: w_next_state = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_to_cnt     <= '0;
      r_history    <= '0;
      r_shot_x     <= 4'd0;
      r_shot_y     <= 4'd0;
      r_shot_big   <= 1'b0;
      r_wrong      <= 1'b0;
      r_led_hit    <= 1'b0;
      r_led_near   <= 1'b0;
      r_led_miss   <= 1'b0;
      r_ship_mask  <= 5'd0;
      r_big_left   <= 2'(BIG_BOMBS);
      r_shots_left <= 5'(MAX_SHOTS);
      r_hit_ones   <= 4'd0;
      r_hit_tens   <= 4'd0;
    end else begin
      if (r_state == StWait) r_to_cnt <= r_to_cnt + TO_W'(1);
      else                   r_to_cnt <= '0;

      if (w_latch) begin
        r_shot_x   <= i_x_in;
        r_shot_y   <= i_y_in;
        r_shot_big <= i_big_req;
      end

      if (w_reject || w_timeout) r_wrong <= 1'b1;
      else if (w_accept)         r_wrong <= 1'b0;

      if (w_commit) begin
        r_led_hit           <= i_res_hit;
        r_led_near          <= i_res_near;
        r_led_miss          <= i_res_miss;
        r_ship_mask         <= r_ship_mask | i_res_ship;
        r_history[w_sq_idx] <= 1'b1;
        r_shots_left        <= w_shots_nxt;
        r_hit_ones          <= w_ones_nxt;
        r_hit_tens          <= w_tens_nxt;
        if (r_shot_big) r_big_left <= r_big_left - 2'd1;
      end
    end
  end

  assign o_shot_x     = r_shot_x;
  assign o_shot_y     = r_shot_y;
  assign o_shot_big   = r_shot_big;
  assign o_score_this = (r_state == StIssue);
  assign o_busy       = (r_state == StIssue) || (r_state == StWait);
  assign o_wrong      = r_wrong;
  assign o_led_hit    = r_led_hit;
  assign o_led_near   = r_led_near;
  assign o_led_miss   = r_led_miss;
  assign o_ship_mask  = r_ship_mask;
  assign o_big_left   = r_big_left;
  assign o_shots_left = r_shots_left;
  assign o_hit_ones   = r_hit_ones;
  assign o_hit_tens   = r_hit_tens;
  assign o_game_over  = (r_state == StOver);

endmodule

// File: doc/shot_sequencer.md
Name: shot_sequencer

Overview:
Initiator side of the Battleship shot/score interface. The block debounces and edge-detects the fire key, latches and validates the X/Y coordinates and the big-bomb request, and then issues a single-cycle score request to the square-checking responder. It waits for the responder's result handshake and keeps the game bookkeeping: hits, shots left, big bombs left, ships hit, fired-square history and game over. It sits between the board switches/KEY and the hit-checking and display logic.

Parameters:
SYNC_STAGES, 2, synchronizer flops on key_n.
DEBOUNCE_CYCLES, 16, cycles key must be stable before a level change is accepted.
MAX_SHOTS, 20, shots per game.
BIG_BOMBS, 2, big bombs per game (must be 0..2).
SHIP_SQUARES, 19, total occupied squares; hit count reaching this ends the game.
TIMEOUT, 15, cycles allowed from score_this to res_valid.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
key_n  in  1  KEY[0], active-low, asynchronous to clock
x_in  in  4  SW[7:4] column
y_in  in  4  SW[3:0] row
big_req  in  1  SW[17] big-bomb request
shot_x  out  4  latched column to responder
shot_y  out  4  latched row to responder
shot_big  out  1  latched big flag to responder
score_this  out  1  one-cycle request pulse
res_valid  in  1  responder result strobe (one cycle)
res_hit, res_near, res_miss  in  1 each  result flags
res_ship  in  5  one-hot biggest ship hit
busy  out  1  high from accept until result or timeout
wrong  out  1  rejected press, drives HEX6/HEX7
led_hit, led_near, led_miss  out  1 each  last result, held
ship_mask  out  5  sticky OR of res_ship
big_left  out  2  big bombs remaining
shots_left  out  5  shots remaining
hit_ones, hit_tens  out  4 each  BCD hit count
game_over  out  1  sticky end of game

Behaviour:
- Reset values: all outputs 0, except big_left=BIG_BOMBS and shots_left=MAX_SHOTS. Fired-square history is cleared. FSM goes to IDLE.
- key_n passes through SYNC_STAGES flops, then a debounce counter. A press event is a one-cycle pulse on the accepted 1->0 transition. Holding the key produces one event.
- FSM states: IDLE, CHECK, ISSUE, WAIT, OVER.
- IDLE:
  - A press event latches x_in/y_in/big_req and moves to CHECK.
  - Events in any other state are discarded.
- CHECK (1 cycle): the press is rejected if any of the following holds:
  - x or y is outside 1..10;
  - big requested while big_left==0;
  - the square is already marked in the 100-bit history.
- On rejection: wrong=1, go to IDLE, no counters change. On acceptance: wrong=0, go to ISSUE.
- wrong holds until the next accepted press or reset.
- ISSUE: score_this=1 for exactly one cycle with shot_x/shot_y/shot_big stable. Go to WAIT. busy is 1 in ISSUE and WAIT.
- WAIT: the shot_* outputs stay stable.
  - res_valid is legal from 1 cycle after score_this onward.
  - On res_valid, in the next cycle:
    - led_* <= res_* flags;
    - ship_mask |= res_ship;
    - history marks the centre square;
    - shots_left decrements;
    - big_left decrements if shot_big;
    - hit count +1 if res_hit (BCD: ones wraps 9->0 with tens+1; saturates at 99).
  - Then the FSM goes to OVER if the new hit count == SHIP_SQUARES or shots_left == 0; otherwise to IDLE.
- Timeout: if TIMEOUT cycles elapse in WAIT without res_valid, set wrong=1, go to IDLE, and commit nothing. A late res_valid arriving in IDLE is ignored.
- Simultaneous res_valid and timeout expiry in the same cycle: res_valid wins.
- OVER: game_over=1, all press events ignored, outputs hold. Only reset leaves OVER.
- Reset mid-WAIT: immediate return to reset values. Any res_valid in the reset cycle is ignored.
- Result flags are not cross-checked; more than one set at once is passed to the LEDs as received.

Test Plan:
- Reset, press with x=7,y=6,big=0, responder answers hit, res_ship=00001 after 3 cycles -> exactly one score_this pulse with shot_x=7, shot_y=6; then led_hit=1, hit_ones=1, shots_left=19, ship_mask=00001.
- Press x=0,y=5, then x=11,y=3 -> wrong=1, no score_this, counters unchanged. Next valid press x=5,y=5 -> wrong=0.
- Two big shots accepted, then a third big request -> big_left goes 2,1,0; third press gives wrong=1, no request. Repeating x=5,y=5 after it was fired -> wrong=1.
- Key bouncing 1 0 1 0 0... shorter than DEBOUNCE_CYCLES, then held low for 100 cycles -> exactly one press event.
- No res_valid for TIMEOUT cycles -> wrong=1, busy=0, shots_left unchanged. A res_valid 5 cycles later is ignored.
- Drive 19 hit results on distinct squares -> hit_tens=1, hit_ones=9, game_over=1, further presses ignored. Separately, 20 misses -> shots_left=0, game_over=1. Reset asserted during WAIT -> all outputs return to reset values next cycle.
